// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO for the pipelined MIPS core.
// Results are computed at accept and committed to HI/LO when busy falls.
module mult_div_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;

    logic             w_accept;
    logic             w_is_md;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic             w_div_signed;
    logic [31:0]      w_div_a;
    logic [31:0]      w_div_b;
    logic [31:0]      w_q_mag;
    logic [31:0]      w_r_mag;
    logic [31:0]      w_quo;
    logic [31:0]      w_rem;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;

    assign w_accept = start & ~flush & ~r_busy & (r_state == S_IDLE);
    assign w_is_md  = ~op[2];

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    assign w_div_signed = (op == OP_DIV);
    assign w_div_a      = (w_div_signed && A[31]) ? (~A + 32'd1) : A;
    assign w_div_b      = (w_div_signed && B[31]) ? (~B + 32'd1) : B;
    assign w_q_mag      = (w_div_b != 32'd0) ? (w_div_a / w_div_b) : 32'd0;
    assign w_r_mag      = (w_div_b != 32'd0) ? (w_div_a % w_div_b) : 32'd0;
    assign w_quo        = (w_div_signed && (A[31] ^ B[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = (w_div_signed && A[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV, OP_DIVU: begin
                if (B != 32'd0) begin
                    w_res_hi = w_rem;
                    w_res_lo = w_quo;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_md) w_state_next = S_RUN;
            S_RUN:  if (r_cnt == '0)         w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else if (w_accept) begin
            case (op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    r_pend_hi <= w_res_hi;
                    r_pend_lo <= w_res_lo;
                    r_cnt     <= op[1] ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);
                    r_busy    <= 1'b1;
                end
                OP_MTHI: r_hi <= A;
                OP_MTLO: r_lo <= A;
                default: ;
            endcase
        end else if (r_state == S_RUN) begin
            if (r_cnt == '0) begin
                r_hi   <= r_pend_hi;
                r_lo   <= r_pend_lo;
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Table-driven bench for mult_div_ctrl plus directed sequences for stall,
// flush and asynchronous reset corners.
module tb_mult_div_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one start pulse for a single cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; flush = fl;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    int          n;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'h00000011, 32'd0,        32'h00000011, 32'h80000000, 0};
        vecs[6]  = '{3'd5, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
        vecs[7]  = '{3'd2, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
        vecs[8]  = '{3'd6, 32'hDEADBEEF, 32'd1,        32'h00000011, 32'h00000022, 0};
        vecs[9]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[11] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

        reset = 1'b1; start = 1'b0; op = 3'd0; flush = 1'b0; A = '0; B = '0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        cur_hi = 32'd0; cur_lo = 32'd0;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            if (vecs[i].cyc > 0) begin
                chk($sformatf("v%0d_hold_hi", i), hi, cur_hi);
                chk($sformatf("v%0d_hold_lo", i), lo, cur_lo);
            end
            count_busy(n);
            chk($sformatf("v%0d_busy_cycles", i), n, vecs[i].cyc);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            $display("vec %0d op=%0d A=%08h B=%08h busy=%0d hi=%08h lo=%08h",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, n, hi, lo);
            cur_hi = vecs[i].hi; cur_lo = vecs[i].lo;
        end

        // Start held during busy must be ignored; MTLO lands in first free cycle.
        issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        start = 1'b1; op = 3'd5; A = 32'h00001234;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("stall_busy_cycles", n, 5);
        chk("stall_lo_after_mult", lo, 32'hFFFFFFFA);
        A = 32'h0000ABCD;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_lo", lo, 32'h0000ABCD);
        chk("b2b_hi", hi, 32'hFFFFFFFF);
        chk("b2b_busy", {31'd0, busy}, 32'd0);
        $display("stall seq busy=%0d hi=%08h lo=%08h", n, hi, lo);

        // Flush masks a same-cycle start.
        issue(3'd0, 32'd5, 32'd5, 1'b1);
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("flush_start_hi", hi, 32'hFFFFFFFF);
        chk("flush_start_lo", lo, 32'h0000ABCD);
        $display("flush start busy=%0b hi=%08h lo=%08h", busy, hi, lo);

        // Flush during RUN does not abort.
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        flush = 1'b1;
        count_busy(n);
        flush = 1'b0;
        chk("flush_run_cycles", n, 10);
        chk("flush_run_hi", hi, 32'd2);
        chk("flush_run_lo", lo, 32'd14);
        $display("flush run busy=%0d hi=%08h lo=%08h", n, hi, lo);

        // Asynchronous reset three cycles into a DIV.
        issue(3'd2, 32'd100, 32'd3, 1'b0);
        @(negedge clk); @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        $display("async reset busy=%0b hi=%08h lo=%08h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b0;
        issue(3'd1, 32'd2, 32'd3, 1'b0);
        count_busy(n);
        chk("post_rst_cycles", n, 5);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd6);
        $display("post reset MULTU busy=%0d hi=%08h lo=%08h", n, hi, lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
